// File: rtl/gb_clk_en_gen.sv
// Clock-enable and reset sequencer for the Game Boy top level.
// A free-running divider on the PLL master clock produces one-cycle enables
// (ce_pix at 2x the ce_cpu rate). A lock-aware FSM holds sys_reset until the
// synchronised PLL lock has been stable for RESET_CYCLES clocks.
module gb_clk_en_gen #(
  parameter int DIV_BITS     = 3,
  parameter int RESET_CYCLES = 1023,
  parameter int SYNC_STAGES  = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic pll_locked,
  input  logic pause,
  input  logic turbo,
  output logic ce_cpu,
  output logic ce_pix,
  output logic sys_reset,
  output logic running
);

  // A zero-width counter is illegal, so RESET_CYCLES = 0 still gets one bit.
  localparam int RCNT_W = (RESET_CYCLES < 1) ? 1 : $clog2(RESET_CYCLES + 1);
  localparam logic [RCNT_W-1:0] RCNT_LOAD = RCNT_W'(RESET_CYCLES);

  typedef enum logic [1:0] {
    S_WAIT_LOCK = 2'd0,
    S_COUNT     = 2'd1,
    S_RUN       = 2'd2
  } state_t;

  logic [DIV_BITS-1:0]    cnt_q, cnt_d;
  logic                   wrap_d;
  logic                   pix_hit_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   locked_s;
  logic                   pause_mode_q, pause_mode_d;
  logic                   turbo_mode_q, turbo_mode_d;
  logic                   pause_eff;
  state_t                 state_q, state_d;
  logic [RCNT_W-1:0]      rcnt_q, rcnt_d;
  logic                   ce_cpu_q, ce_cpu_d;
  logic                   ce_pix_q, ce_pix_d;
  logic                   sys_reset_q, sys_reset_d;
  logic                   running_q, running_d;

  // Enables are decoded from the value the counter is about to take, so the
  // registered pulse lands on the edge where that count is reached.
  assign cnt_d  = cnt_q + DIV_BITS'(1);
  assign wrap_d = (cnt_d == '0);

  generate
    if (DIV_BITS == 1) begin : g_pix_always
      assign pix_hit_d = 1'b1;
    end else begin : g_pix_div
      assign pix_hit_d = (cnt_d[DIV_BITS-2:0] == '0);
    end
  endgenerate

  assign locked_s = sync_q[SYNC_STAGES-1];

  // Modes change only on the wrap edge, so a CPU period is never cut short
  // or doubled. The freshly sampled value already governs the wrap pulse.
  assign pause_mode_d = wrap_d ? pause : pause_mode_q;
  assign turbo_mode_d = wrap_d ? turbo : turbo_mode_q;

  // The core must keep seeing enabled edges while it is held in reset.
  assign pause_eff = pause_mode_d & ~sys_reset_q;

  assign ce_pix_d = pix_hit_d;
  assign ce_cpu_d = pix_hit_d & (wrap_d | turbo_mode_d) & ~pause_eff;

  // Reset sequencer next-state: wait for lock, count down, run; losing lock
  // anywhere restarts the whole sequence.
  always_comb begin
    state_d = state_q;
    rcnt_d  = rcnt_q;
    case (state_q)
      S_WAIT_LOCK: begin
        rcnt_d = RCNT_LOAD;
        if (locked_s) state_d = S_COUNT;
      end
      S_COUNT: begin
        if (rcnt_q == '0) state_d = S_RUN;
        else              rcnt_d  = rcnt_q - RCNT_W'(1);
      end
      S_RUN: begin
        state_d = S_RUN;
      end
      default: begin
        state_d = S_WAIT_LOCK;
        rcnt_d  = RCNT_LOAD;
      end
    endcase
    if (!locked_s) begin
      state_d = S_WAIT_LOCK;
      rcnt_d  = RCNT_LOAD;
    end
  end

  assign sys_reset_d = (state_d != S_RUN);
  assign running_d   = (state_d == S_RUN);

  // Divider, lock synchroniser, mode latches, FSM and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q        <= '0;
      sync_q       <= '0;
      pause_mode_q <= 1'b0;
      turbo_mode_q <= 1'b0;
      state_q      <= S_WAIT_LOCK;
      rcnt_q       <= RCNT_LOAD;
      ce_cpu_q     <= 1'b0;
      ce_pix_q     <= 1'b0;
      sys_reset_q  <= 1'b1;
      running_q    <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      sync_q       <= {sync_q[SYNC_STAGES-2:0], pll_locked};
      pause_mode_q <= pause_mode_d;
      turbo_mode_q <= turbo_mode_d;
      state_q      <= state_d;
      rcnt_q       <= rcnt_d;
      ce_cpu_q     <= ce_cpu_d;
      ce_pix_q     <= ce_pix_d;
      sys_reset_q  <= sys_reset_d;
      running_q    <= running_d;
    end
  end

  assign ce_cpu    = ce_cpu_q;
  assign ce_pix    = ce_pix_q;
  assign sys_reset = sys_reset_q;
  assign running   = running_q;

endmodule

// File: tb/tb_gb_clk_en_gen.sv
// Directed bench for gb_clk_en_gen (DIV_BITS=3, RESET_CYCLES=1023, SYNC_STAGES=2).
// Edges are numbered from the first rising edge after reset_n release; every
// edge is checked against the expected enable pattern and reset state.
module tb_gb_clk_en_gen;

  logic clk;
  logic reset_n;
  logic pll_locked;
  logic pause;
  logic turbo;
  logic ce_cpu;
  logic ce_pix;
  logic sys_reset;
  logic running;

  int n_vec;
  int n_err;
  int k;          // edges since reset_n release
  logic turbo_m;  // bench copy of the mode latched at each wrap
  logic pause_m;
  logic rst_prev; // expected sys_reset before the current edge

  gb_clk_en_gen #(
    .DIV_BITS    (3),
    .RESET_CYCLES(1023),
    .SYNC_STAGES (2)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .pll_locked(pll_locked),
    .pause     (pause),
    .turbo     (turbo),
    .ce_cpu    (ce_cpu),
    .ce_pix    (ce_pix),
    .sys_reset (sys_reset),
    .running   (running)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at edge %0d: got %0h expected %0h", tag, k, got, exp);
    end
  endtask

  // One rising edge, then compare all outputs against the expected pattern.
  // ce_pix every 4 edges, ce_cpu on every 8th (wrap) edge, or with every
  // ce_pix in turbo; pause (latched at wrap) blanks ce_cpu unless in reset.
  task automatic tick(input logic exp_rst);
    logic pix, wrap, cpu;
    @(posedge clk);
    k++;
    pix  = (k % 4 == 0);
    wrap = (k % 8 == 0);
    if (wrap) begin
      turbo_m = turbo;
      pause_m = pause;
    end
    cpu = pix && (wrap || turbo_m) && !(pause_m && !rst_prev);
    rst_prev = exp_rst;
    #1;
    check_val("ce_pix",    {31'd0, ce_pix},    {31'd0, pix});
    check_val("ce_cpu",    {31'd0, ce_cpu},    {31'd0, cpu});
    check_val("sys_reset", {31'd0, sys_reset}, {31'd0, exp_rst});
    check_val("running",   {31'd0, running},   {31'd0, ~exp_rst});
  endtask

  task automatic model_reset();
    k        = 0;
    turbo_m  = 1'b0;
    pause_m  = 1'b0;
    rst_prev = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at edge %0d", k);
    $fatal(1, "watchdog");
  end

  initial begin
    int j;
    n_vec      = 0;
    n_err      = 0;
    reset_n    = 1'b0;
    pll_locked = 1'b0;
    pause      = 1'b0;
    turbo      = 1'b0;
    model_reset();

    // Reset state while reset_n held low across several edges.
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_ce_cpu",    {31'd0, ce_cpu},    32'd0);
    check_val("rst_ce_pix",    {31'd0, ce_pix},    32'd0);
    check_val("rst_sys_reset", {31'd0, sys_reset}, 32'd1);
    check_val("rst_running",   {31'd0, running},   32'd0);
    $display("reset hold: outputs checked");

    // Lock present from release; async reset mid-count after a ce_cpu edge.
    pll_locked = 1'b1;
    #2 reset_n = 1'b1;
    model_reset();
    for (int i = 0; i < 200; i++) tick(1'b1);
    #2 reset_n = 1'b0;
    #1;
    check_val("async_ce_cpu",    {31'd0, ce_cpu},    32'd0);
    check_val("async_ce_pix",    {31'd0, ce_pix},    32'd0);
    check_val("async_sys_reset", {31'd0, sys_reset}, 32'd1);
    check_val("async_running",   {31'd0, running},   32'd0);
    $display("async reset at edge %0d: outputs checked", k);

    // Restart from S_WAIT_LOCK; pause during sys_reset must be ignored.
    // sys_reset falls on edge 1027 = 1026 edges after lock is first sampled.
    #2 reset_n = 1'b1;
    model_reset();
    while (k < 1030) begin
      pause = (k >= 20 && k < 100);
      tick(k + 1 < 1027);
    end
    pause = 1'b0;
    $display("lock sequence: sys_reset release checked through edge %0d", k);

    // Turbo raised mid-period, then lowered.
    while (k < 1070) begin
      turbo = (k >= 1034 && k < 1050);
      tick(1'b0);
    end
    turbo = 1'b0;
    $display("turbo: enable pattern checked through edge %0d", k);

    // Pause while running.
    while (k < 1100) begin
      pause = (k >= 1075 && k < 1090);
      tick(1'b0);
    end
    pause = 1'b0;
    $display("pause: enable pattern checked through edge %0d", k);

    // Lock dropped for 5 edges, then full sequence after relock.
    j = k;
    while (k < j + 1040) begin
      pll_locked = !(k >= j && k < j + 5);
      tick((k + 1 >= j + 3) && (k + 1 < j + 1032));
    end
    pll_locked = 1'b1;
    $display("lock loss: resequence checked through edge %0d", k);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
